// File: rtl/sd_cmd_issuer_if.sv
// sd_cmd_issuer_if: link between the command issuer and the SD command serialiser.
//   master modport : issuer side (drives SETTING_O, CMD_O, REQ_O, ACK_O)
//   slave modport  : serialiser side (drives ACK_I, REQ_I, STATUS_I, CMD_I)
// SETTING_O : 16-bit setting word       CMD_O    : 40-bit command word
// REQ_O     : command request           ACK_I    : serialiser ack, low = busy/accepted
// REQ_I     : status request            STATUS_I : [3:0] phase, [5] crc ok, [6] phase end
// CMD_I     : 40-bit response word      ACK_O    : status acknowledge
interface sd_cmd_issuer_if;
  logic [15:0] SETTING_O;
  logic [39:0] CMD_O;
  logic        REQ_O;
  logic        ACK_I;
  logic        REQ_I;
  logic [7:0]  STATUS_I;
  logic [39:0] CMD_I;
  logic        ACK_O;

  modport master (
    output SETTING_O, CMD_O, REQ_O, ACK_O,
    input  ACK_I, REQ_I, STATUS_I, CMD_I
  );

  modport slave (
    input  SETTING_O, CMD_O, REQ_O, ACK_O,
    output ACK_I, REQ_I, STATUS_I, CMD_I
  );
endinterface

// File: rtl/sd_cmd_issuer.sv
// sd_cmd_issuer: command-issue stage in front of the SD command serialiser.
// Takes one command at a time, packs it into the serialiser command/setting
// words, runs both request/acknowledge handshakes, captures the response and
// reports completion, CRC error, index mismatch, refused start or timeout.
//
// Ports:
//   SD_CLK_IN, RST_IN (async, active high)
//   start_i, cmd_index_i, arg_i, rsp_type_i, crc_chk_i, idx_chk_i,
//   blk_rd_i, blk_wr_i, word_sel_i        : command launch side
//   busy_o, done_o, err_o{tmo,refused,idx,crc}, rsp_o, rsp_idx_o : status side
//   ser (sd_cmd_issuer_if.master)         : serialiser handshake
//
// Optional: define SD_CMD_ISSUER_RETRY_EN to re-issue a command once after a
// response CRC failure.
module sd_cmd_issuer #(
  parameter logic [15:0] TIMEOUT        = 16'd4096,
  parameter logic [6:0]  LONG_RSP_SIZE  = 7'd127,
  parameter logic [6:0]  SHORT_RSP_SIZE = 7'd40
) (
  input  logic                  SD_CLK_IN,
  input  logic                  RST_IN,
  input  logic                  start_i,
  input  logic [5:0]            cmd_index_i,
  input  logic [31:0]           arg_i,
  input  logic [1:0]            rsp_type_i,
  input  logic                  crc_chk_i,
  input  logic                  idx_chk_i,
  input  logic                  blk_rd_i,
  input  logic                  blk_wr_i,
  input  logic [1:0]            word_sel_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [3:0]            err_o,
  output logic [31:0]           rsp_o,
  output logic [5:0]            rsp_idx_o,
  sd_cmd_issuer_if.master       ser
);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    SEND    = 5'b00010,
    EXEC    = 5'b00100,
    RELEASE = 5'b01000,
    FINISH  = 5'b10000
  } state_t;

  state_t      state_q, state_d;
  logic        ack_m, ack_s, req_m, req_s;
  logic [15:0] tmo_cnt;
  logic [5:0]  idx_q;
  logic        crc_chk_q, idx_chk_q;
  logic [6:0]  rsp_size;

  // one-cycle actions decoded by the next-state logic
  logic accept, refuse, send_go, rsp_take, tmo_hit, rel_done, retry_go;
  logic rsp_done, rsp_none;

`ifdef SD_CMD_ISSUER_RETRY_EN
  logic retry_q;
`endif

  // Only bits the issuer interprets; the rest belong to the serialiser.
  logic unused_bits;
  assign unused_bits = &{1'b0, ser.STATUS_I[7], ser.STATUS_I[4], ser.CMD_I[39:38]};

  always_comb begin
    case (rsp_type_i)
      2'b00:   rsp_size = 7'd0;
      2'b10:   rsp_size = LONG_RSP_SIZE;
      default: rsp_size = SHORT_RSP_SIZE;  // 01 and 11
    endcase
  end

  // STATUS_I is only trusted while the synchronised request is high.
  assign rsp_done = req_s && ser.STATUS_I[6] && (ser.STATUS_I[3:0] == 4'b0110);
  assign rsp_none = req_s && (ser.STATUS_I[3:0] == 4'b0100);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    refuse   = 1'b0;
    send_go  = 1'b0;
    rsp_take = 1'b0;
    tmo_hit  = 1'b0;
    rel_done = 1'b0;
    retry_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ack_s) begin
            accept  = 1'b1;
            state_d = SEND;
          end else begin
            refuse  = 1'b1;
          end
        end
      end
      SEND: begin
        if (!ack_s) begin
          send_go = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // response is checked first so it wins over a same-cycle timeout
        if (rsp_done) begin
          rsp_take = 1'b1;
          state_d  = RELEASE;
        end else if (rsp_none) begin
          state_d  = RELEASE;
        end else if (tmo_cnt == TIMEOUT - 16'd1) begin
          // this cycle's increment makes the count reach TIMEOUT
          tmo_hit  = 1'b1;
          state_d  = FINISH;
        end
      end
      RELEASE: begin
        if (!req_s && ack_s) begin
          rel_done = 1'b1;
          state_d  = FINISH;
`ifdef SD_CMD_ISSUER_RETRY_EN
          if (err_o[0] && !retry_q) begin
            rel_done = 1'b0;
            retry_go = 1'b1;
            state_d  = SEND;
          end
`endif
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q       <= IDLE;
      ack_m         <= 1'b0;
      ack_s         <= 1'b0;
      req_m         <= 1'b0;
      req_s         <= 1'b0;
      tmo_cnt       <= '0;
      idx_q         <= '0;
      crc_chk_q     <= 1'b0;
      idx_chk_q     <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= '0;
      rsp_o         <= '0;
      rsp_idx_o     <= '0;
      ser.SETTING_O <= '0;
      ser.CMD_O     <= '0;
      ser.REQ_O     <= 1'b0;
      ser.ACK_O     <= 1'b0;
`ifdef SD_CMD_ISSUER_RETRY_EN
      retry_q       <= 1'b0;
`endif
    end else begin
      ack_m   <= ser.ACK_I;
      ack_s   <= ack_m;
      req_m   <= ser.REQ_I;
      req_s   <= req_m;
      state_q <= state_d;
      done_o  <= 1'b0;

      if (accept) begin
        ser.CMD_O     <= {2'b01, cmd_index_i, arg_i};
        ser.SETTING_O <= {1'b0, word_sel_i, blk_rd_i, blk_wr_i, 3'd2, crc_chk_i, rsp_size};
        idx_q         <= cmd_index_i;
        crc_chk_q     <= crc_chk_i;
        idx_chk_q     <= idx_chk_i;
        err_o         <= '0;
        busy_o        <= 1'b1;
        ser.REQ_O     <= 1'b1;
`ifdef SD_CMD_ISSUER_RETRY_EN
        retry_q       <= 1'b0;
`endif
      end

      // serialiser still busy: refuse without touching the held command
      if (refuse) begin
        err_o  <= 4'b0100;
        done_o <= 1'b1;
      end

      if (send_go) begin
        ser.REQ_O <= 1'b0;
        tmo_cnt   <= '0;
      end else if (state_q == EXEC) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (rsp_take) begin
        rsp_o     <= ser.CMD_I[31:0];
        rsp_idx_o <= ser.CMD_I[37:32];
        err_o[0]  <= crc_chk_q & ~ser.STATUS_I[5];
        err_o[1]  <= idx_chk_q & (ser.CMD_I[37:32] != idx_q);
        ser.ACK_O <= 1'b1;
      end

      if (tmo_hit)  err_o[3]  <= 1'b1;
      if (rel_done) ser.ACK_O <= 1'b0;

      if (retry_go) begin
        ser.ACK_O <= 1'b0;
        ser.REQ_O <= 1'b1;
        err_o[0]  <= 1'b0;
`ifdef SD_CMD_ISSUER_RETRY_EN
        retry_q   <= 1'b1;
`endif
      end

      // completion is flagged while the FSM sits in FINISH
      if (state_d == FINISH && state_q != FINISH) begin
        done_o <= 1'b1;
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_issuer.sv
`timescale 1ns/1ps
module tb_sd_cmd_issuer;
  logic        SD_CLK_IN = 1'b0;
  logic        RST_IN;
  logic        start_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] arg_i;
  logic [1:0]  rsp_type_i;
  logic        crc_chk_i, idx_chk_i, blk_rd_i, blk_wr_i;
  logic [1:0]  word_sel_i;
  logic        busy_o, done_o;
  logic [3:0]  err_o;
  logic [31:0] rsp_o;
  logic [5:0]  rsp_idx_o;

  sd_cmd_issuer_if ser();

  sd_cmd_issuer #(.TIMEOUT(16'd64)) dut (
    .SD_CLK_IN   (SD_CLK_IN),
    .RST_IN      (RST_IN),
    .start_i     (start_i),
    .cmd_index_i (cmd_index_i),
    .arg_i       (arg_i),
    .rsp_type_i  (rsp_type_i),
    .crc_chk_i   (crc_chk_i),
    .idx_chk_i   (idx_chk_i),
    .blk_rd_i    (blk_rd_i),
    .blk_wr_i    (blk_wr_i),
    .word_sel_i  (word_sel_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rsp_o       (rsp_o),
    .rsp_idx_o   (rsp_idx_o),
    .ser         (ser)
  );

  always #5 SD_CLK_IN = ~SD_CLK_IN;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // event monitor, sampled just after each rising edge
  int   cyc = 0, req_rises = 0, done_cnt = 0, ack_hi = 0, last_exec = 0, last_done = 0;
  logic req_prev = 1'b0;
  always @(posedge SD_CLK_IN) begin
    #1;
    cyc++;
    if (ser.REQ_O === 1'b1 && req_prev === 1'b0) req_rises++;
    if (ser.REQ_O === 1'b0 && req_prev === 1'b1) last_exec = cyc;
    req_prev = ser.REQ_O;
    if (done_o === 1'b1) begin done_cnt++; last_done = cyc; end
    if (ser.ACK_O === 1'b1) ack_hi++;
  end

  // reference-model state: last captured response
  logic [31:0] exp_rsp = '0;
  logic [5:0]  exp_ridx = '0;

  task automatic tick();
    @(negedge SD_CLK_IN);
  endtask

  function automatic logic [15:0] model_setting(input logic [1:0] rt, input logic cc,
      input logic rd, input logic wr, input logic [1:0] ws);
    int sz;
    sz = (rt == 2'd0) ? 0 : (rt == 2'd2) ? 127 : 40;
    return 16'(sz + 128 * int'(cc) + 2 * 256 + 2048 * int'(wr) + 4096 * int'(rd) + 8192 * int'(ws));
  endfunction

  task automatic launch(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
      input logic cc, input logic ic, input logic rd, input logic wr, input logic [1:0] ws);
    cmd_index_i = idx; arg_i = arg; rsp_type_i = rt; crc_chk_i = cc; idx_chk_i = ic;
    blk_rd_i = rd; blk_wr_i = wr; word_sel_i = ws;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
      input logic cc, input logic ic, input logic rd, input logic wr, input logic [1:0] ws,
      input logic crc_ok, input logic [5:0] ridx, input logic [31:0] rword,
      input bit inter, input bit poke);
    int r0, d0, a0, n, attempts;
    logic [39:0] exp_cmd;
    logic [15:0] exp_set;
    logic [3:0]  exp_err;
    logic [2:0]  ph;
    bit          noresp;
    r0 = req_rises; d0 = done_cnt; a0 = ack_hi;
    exp_cmd = {2'b01, idx, arg};
    exp_set = model_setting(rt, cc, rd, wr, ws);
    noresp  = (rt == 2'd0);
    exp_err = noresp ? 4'b0000 : {2'b00, ic && (ridx != idx), cc && !crc_ok};
    attempts = 1;
`ifdef SD_CMD_ISSUER_RETRY_EN
    if (!noresp && cc && !crc_ok) attempts = 2;
`endif
    if (!noresp) begin exp_rsp = rword; exp_ridx = ridx; end

    launch(idx, arg, rt, cc, ic, rd, wr, ws);
    chk("accept_busy", busy_o, 1);
    chk("accept_req", ser.REQ_O, 1);
    chk("cmd_word", ser.CMD_O, exp_cmd);
    chk("setting_word", ser.SETTING_O, exp_set);
    chk("err_cleared", err_o, 0);

    for (int a = 0; a < attempts; a++) begin
      n = 0;
      while (ser.REQ_O !== 1'b1 && n < 20) begin tick(); n++; end
      chk("req_up", ser.REQ_O, 1);
      ser.ACK_I = 1'b0;
      n = 0;
      while (ser.REQ_O !== 1'b0 && n < 20) begin tick(); n++; end
      chk("req_drop", ser.REQ_O, 0);
      repeat ($urandom_range(1, 6)) tick();
      if (poke) begin
        start_i = 1'b1; cmd_index_i = ~idx;
        tick();
        start_i = 1'b0; cmd_index_i = idx;
        chk("poke_cmd_held", ser.CMD_O, exp_cmd);
        chk("poke_busy", busy_o, 1);
      end
      if (inter) begin
        ph = 3'($urandom_range(0, 3));
        ser.STATUS_I = 8'h40 | ((ph == 3'd3) ? 8'h05 : {5'b0, ph + 3'd1});
        ser.REQ_I = 1'b1;
        repeat (4) tick();
        ser.REQ_I = 1'b0;
        repeat (3) tick();
      end
      ser.STATUS_I = noresp ? 8'h44 : {1'b0, 1'b1, crc_ok, 1'b0, 4'b0110};
      ser.CMD_I    = {2'b00, ridx, rword};
      ser.REQ_I    = 1'b1;
      if (!noresp) begin
        n = 0;
        while (ser.ACK_O !== 1'b1 && n < 20) begin tick(); n++; end
        chk("ack_up", ser.ACK_O, 1);
      end else begin
        repeat (5) tick();
      end
      ser.REQ_I = 1'b0;
      ser.ACK_I = 1'b1;
    end

    n = 0;
    while (done_o !== 1'b1 && n < 30) begin tick(); n++; end
    chk("done", done_o, 1);
    chk("err", err_o, exp_err);
    chk("rsp", rsp_o, exp_rsp);
    chk("rsp_idx", rsp_idx_o, exp_ridx);
    chk("busy_clear", busy_o, 0);
    chk("cmd_held", ser.CMD_O, exp_cmd);
    chk("setting_held", ser.SETTING_O, exp_set);
    tick();
    chk("done_one_cycle", done_o, 0);
    chk("req_rises", req_rises - r0, attempts);
    chk("done_count", done_cnt - d0, 1);
    if (noresp) chk("ack_never", ack_hi - a0, 0);
    repeat (2) tick();
  endtask

  initial begin
    int n, d0;
    RST_IN = 1'b1; start_i = 1'b0; cmd_index_i = '0; arg_i = '0; rsp_type_i = '0;
    crc_chk_i = 1'b0; idx_chk_i = 1'b0; blk_rd_i = 1'b0; blk_wr_i = 1'b0; word_sel_i = '0;
    ser.ACK_I = 1'b1; ser.REQ_I = 1'b0; ser.STATUS_I = '0; ser.CMD_I = '0;
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rsp", rsp_o, 0);
    chk("rst_rsp_idx", rsp_idx_o, 0);
    chk("rst_setting", ser.SETTING_O, 0);
    chk("rst_cmd", ser.CMD_O, 0);
    chk("rst_req", ser.REQ_O, 0);
    chk("rst_ack", ser.ACK_O, 0);
    RST_IN = 1'b0;
    repeat (4) tick();

    // short, no-response, bad CRC, index mismatch, long
    run_cmd(6'd8, 32'h1AA, 2'b01, 1, 0, 0, 0, 2'd0, 1, 6'd8, 32'h1AA, 0, 0);
    run_cmd(6'd0, 32'h0, 2'b00, 0, 0, 0, 0, 2'd0, 1, 6'd0, 32'h0, 1, 0);
    run_cmd(6'd13, 32'hDEAD_0001, 2'b01, 1, 0, 0, 0, 2'd0, 0, 6'd13, 32'h900, 0, 0);
    run_cmd(6'd17, 32'h200, 2'b01, 1, 1, 1, 0, 2'd1, 1, 6'd16, 32'h0000_0900, 0, 1);
    run_cmd(6'd2, 32'h0, 2'b10, 0, 0, 0, 1, 2'd3, 1, 6'd63, 32'hCAFE_F00D, 1, 0);

    // timeout, then refused start while the serialiser stays busy
    launch(6'd24, 32'h1234, 2'b01, 1, 1, 0, 1, 2'd0);
    ser.ACK_I = 1'b0;
    n = 0;
    while (ser.REQ_O !== 1'b0 && n < 20) begin tick(); n++; end
    chk("tmo_req_drop", ser.REQ_O, 0);
    n = 0;
    while (done_o !== 1'b1 && n < 100) begin tick(); n++; end
    chk("tmo_done", done_o, 1);
    chk("tmo_latency", last_done - last_exec, 64);
    chk("tmo_err", err_o, 4'b1000);
    chk("tmo_rsp_held", rsp_o, exp_rsp);
    chk("tmo_busy", busy_o, 0);
    tick();
    start_i = 1'b1; cmd_index_i = 6'd5;
    tick();
    start_i = 1'b0;
    chk("refuse_done", done_o, 1);
    chk("refuse_err", err_o, 4'b0100);
    chk("refuse_busy", busy_o, 0);
    chk("refuse_req", ser.REQ_O, 0);
    chk("refuse_cmd_held", ser.CMD_O, {2'b01, 6'd24, 32'h1234});
    tick();
    chk("refuse_done_1cyc", done_o, 0);
    ser.ACK_I = 1'b1;
    repeat (4) tick();

    // reset while in EXEC
    d0 = done_cnt;
    launch(6'd9, 32'h55, 2'b10, 1, 1, 0, 0, 2'd2);
    ser.ACK_I = 1'b0;
    n = 0;
    while (ser.REQ_O !== 1'b0 && n < 20) begin tick(); n++; end
    chk("rstx_exec", ser.REQ_O, 0);
    repeat (3) tick();
    RST_IN = 1'b1;
    tick();
    chk("rstx_busy", busy_o, 0);
    chk("rstx_err", err_o, 0);
    chk("rstx_rsp", rsp_o, 0);
    chk("rstx_cmd", ser.CMD_O, 0);
    chk("rstx_setting", ser.SETTING_O, 0);
    exp_rsp = '0; exp_ridx = '0;
    ser.ACK_I = 1'b1; ser.REQ_I = 1'b0;
    tick();
    RST_IN = 1'b0;
    repeat (4) tick();
    chk("rstx_no_done", done_cnt - d0, 0);
    run_cmd(6'd8, 32'h1AA, 2'b01, 1, 0, 0, 0, 2'd0, 1, 6'd8, 32'h1AA, 0, 0);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      logic [5:0] idx, ridx;
      idx  = 6'($urandom);
      ridx = ($urandom_range(0, 2) == 0) ? 6'($urandom) : idx;
      run_cmd(idx, $urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), ridx, $urandom,
              1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sd_cmd_issuer.md
Name: sd_cmd_issuer

Overview:
Command-issue stage directly upstream of the SD command serialiser.
- Accepts one command at a time from the controller register and DMA side.
- Packs the command into the serialiser's 40-bit command word and 16-bit setting word.
- Runs the request/acknowledge handshakes with the serialiser and captures the response and status.
- Reports completion, CRC error, index mismatch or timeout to the software-visible layer.

Parameters:
- TIMEOUT, 16'd4096: SD clocks allowed in EXEC before a timeout is declared.
- LONG_RSP_SIZE, 7'd127: setting-word response size used for 136-bit responses.
- SHORT_RSP_SIZE, 7'd40: setting-word response size used for 48-bit responses.

Ports:
- SD_CLK_IN, input, 1: SD clock; all logic on its rising edge.
- RST_IN, input, 1: reset, asynchronous, active-high.
- start_i, input, 1: single-cycle command launch strobe.
- cmd_index_i, input, 6: command index.
- arg_i, input, 32: command argument.
- rsp_type_i, input, 2: 00 none, 01 short, 10 long, 11 treated as short.
- crc_chk_i, input, 1: enable response CRC check.
- idx_chk_i, input, 1: enable response index check.
- blk_rd_i, input, 1: command starts a block read.
- blk_wr_i, input, 1: command starts a block write.
- word_sel_i, input, 2: response word to capture (long responses).
- busy_o, output, 1: command in flight.
- done_o, output, 1: one-cycle completion pulse.
- err_o, output, 4: {timeout, start_refused, index_err, crc_err}.
- rsp_o, output, 32: captured response word.
- rsp_idx_o, output, 6: index field of the response.
- SETTING_O, output, 16: setting word to the serialiser.
- CMD_O, output, 40: command word to the serialiser.
- REQ_O, output, 1: request to the serialiser.
- ACK_I, input, 1: serialiser acknowledge; low means a command is accepted or in progress.
- REQ_I, input, 1: serialiser status request.
- STATUS_I, input, 8: serialiser status; [3:0] phase code, [5] CRC valid, [6] phase end.
- CMD_I, input, 40: response word from the serialiser.
- ACK_O, output, 1: acknowledge to the serialiser.

Behaviour:
- Reset values: busy_o=0, done_o=0, err_o=0, rsp_o=0, rsp_idx_o=0, SETTING_O=0, CMD_O=0, REQ_O=0, ACK_O=0. State is IDLE and all synchronisers are 0.
- ACK_I and REQ_I each pass through a 2-flop synchroniser (ack_s, req_s) before use. STATUS_I and CMD_I are sampled only while req_s=1; they are stable by then.
- CMD_O word: {2'b01, cmd_index_i, arg_i}.
- SETTING_O word:
  - [6:0] = 0 for none, SHORT_RSP_SIZE for short, LONG_RSP_SIZE for long.
  - [7] = crc_chk_i; [10:8] = 3'd2; [11] = blk_wr_i; [12] = blk_rd_i; [14:13] = word_sel_i; [15] = 0.
  - CMD_O and SETTING_O are registered on accept and held stable until the next accept.
- State machine (one-hot):
  - IDLE:
    - start_i with ack_s=1: latch inputs, busy_o=1, REQ_O=1, go to SEND.
    - start_i with ack_s=0 (serialiser still busy): set err_o[2], pulse done_o, stay in IDLE.
  - SEND: REQ_O held at 1 until ack_s=0, then REQ_O=0 and go to EXEC. The timeout counter is cleared on entry.
  - EXEC: timeout counter increments every cycle.
    - req_s=1 with STATUS_I[6]=1 and STATUS_I[3:0]=0110:
      - rsp_o = CMD_I[31:0], rsp_idx_o = CMD_I[37:32].
      - err_o[0] = crc_chk & ~STATUS_I[5].
      - err_o[1] = idx_chk & (CMD_I[37:32] != latched index).
      - ACK_O=1, go to RELEASE.
    - req_s=1 with STATUS_I[3:0]=0100 (no-response command): go to RELEASE with ACK_O=0.
    - Counter reaches TIMEOUT: err_o[3]=1, go to FINISH.
  - RELEASE: hold ACK_O until req_s=0 and ack_s=1. Then ACK_O=0, go to FINISH.
  - FINISH: done_o=1 for one cycle, busy_o=0, go to IDLE.
- Error bits clear on the next accepted start_i. rsp_o holds its value until the next response.
- start_i outside IDLE is ignored with no error.
- Intermediate serialiser phases (0001, 0010, 0011, 0101) are ignored; ACK_O is never raised for them.
- Simultaneous timeout and response-done in the same cycle: the response wins.
- RST_IN mid-operation returns to reset values immediately, with no done_o pulse.

Optional Feature:
- Macro: SD_CMD_ISSUER_RETRY_EN.
- Defined: a response with err_o[0] set and no previous retry goes from RELEASE back to SEND (REQ_O=1) instead of FINISH. CMD_O and SETTING_O are unchanged, err_o[0] is cleared and a retry flag is set. A second CRC failure completes normally with err_o[0]=1.
- Undefined: no retry logic; a CRC error always completes at once.

Test Plan:
- Short command: start_i, cmd 8, arg 0x000001AA, rsp_type 01, crc on. Model returns status 0110 with [5]=1 and CMD_I={2'b00,6'd8,32'h1AA} -> CMD_O=40'h48000001AA, SETTING_O[6:0]=40, rsp_o=0x1AA, err_o=0, one done_o pulse.
- No-response command: cmd 0, rsp_type 00 -> SETTING_O[6:0]=0; status 0100 -> done_o with err_o=0 and ACK_O never high.
- Bad CRC: status 0110 with [5]=0 -> err_o=4'b0001 without the macro; with SD_CMD_ISSUER_RETRY_EN, exactly two REQ_O rises.
- Index mismatch: cmd 17 with response index 16 and idx_chk on -> err_o=4'b0010.
- Timeout: TIMEOUT=64 and the model never sends status -> done_o at EXEC entry+64 with err_o=4'b1000. A following start_i while ACK_I is low -> err_o=4'b0100.
- Reset asserted in EXEC -> all outputs 0 on the next sample and no done_o; a new command after reset completes normally.
